// File: rtl/dmem_sram_resp_pkg.sv
// Shared definitions for the data-memory responder: bus widths, the
// responder state encoding and the bad-status codes.
package dmem_sram_resp_pkg;

    // Core data-memory bus geometry
    localparam int DM_DATA_LEN = 64;
    localparam int DM_ADDR_LEN = 32;

    // Derived lane geometry
    localparam int DM_BYTES = DM_DATA_LEN / 8;
    localparam int DM_OFF_W = $clog2(DM_BYTES);

    typedef logic [DM_DATA_LEN-1:0] dm_data_t;
    typedef logic [DM_ADDR_LEN-1:0] dm_addr_t;
    typedef logic [DM_BYTES-1:0]    dm_be_t;

    // Responder sequencing: IDLE accepts, WAIT burns wait states
    typedef enum logic [0:0] {
        DMEM_RESP_IDLE = 1'b0,
        DMEM_RESP_WAIT = 1'b1
    } dmem_resp_state_e;

    // dmem_bad encodings: bit 0 page fault, bit 1 access fault
    localparam logic [1:0] DMEM_BAD_NONE = 2'b00;
    localparam logic [1:0] DMEM_BAD_XES  = 2'b10;

endpackage

// File: rtl/dmem_sram_resp_if.sv
// Data-memory request/response bundle between the load/store unit
// (master) and a memory responder (slave).
interface dmem_sram_resp_if;
    import dmem_sram_resp_pkg::*;

    logic     dmem_req;
    dm_addr_t dmem_addr;
    logic     dmem_wr;
    logic     dmem_ex;
    dm_be_t   dmem_byte;
    dm_data_t dmem_wdata;
    dm_data_t dmem_rdata;
    logic [1:0] dmem_bad;
    logic     dmem_xstate;
    logic     dmem_busy;

    modport master (
        output dmem_req, dmem_addr, dmem_wr, dmem_ex, dmem_byte, dmem_wdata,
        input  dmem_rdata, dmem_bad, dmem_xstate, dmem_busy
    );

    modport slave (
        input  dmem_req, dmem_addr, dmem_wr, dmem_ex, dmem_byte, dmem_wdata,
        output dmem_rdata, dmem_bad, dmem_xstate, dmem_busy
    );

endinterface

// File: rtl/dmem_sram_resp_excl_mon.sv
// Single-entry reservation monitor for LR/SC/AMO sequences. xstate is the
// combinational verdict for the transaction presented on ex/wr/idx; the
// entry itself only changes when commit is asserted.
module dmem_excl_mon #(
    parameter int IDX_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             commit,
    input  logic             ex,
    input  logic             wr,
    input  logic [IDX_W-1:0] idx,
    output logic             xstate
);

    logic             valid_q, valid_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             hit;

    // Verdict and next reservation for the transaction being committed
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can hold a value and infer a latch.
        valid_d = valid_q;
        idx_d   = idx_q;
        hit     = valid_q && (idx_q == idx);
        // Exclusive load always succeeds; exclusive store only on a live match
        xstate  = ex && (!wr || hit);
        if (commit) begin
            if (ex && !wr) begin
                valid_d = 1'b1;
                idx_d   = idx;
            end else if (ex && wr) begin
                valid_d = 1'b0;
            end else if (wr && hit) begin
                valid_d = 1'b0;
            end
        end
    end

    // Reservation entry register
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
        if (rst) begin
            valid_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            valid_q <= valid_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: rtl/dmem_sram_resp.sv
// Data-memory responder: byte-lane SRAM array with programmable wait
// states, range-fault reporting and an exclusive-access monitor. All
// side effects and response outputs commit at the edge that ends the
// transaction (the accept edge when WAIT = 0, else the last wait edge).
module dmem_sram_resp
    import dmem_sram_resp_pkg::*;
#(
    parameter dm_addr_t    BASE  = '0,
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned WAIT  = 0
) (
    input  logic            clk,
    input  logic            rst,
    dmem_sram_resp_if.slave dmem
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One past the last valid byte address, one bit wider so it cannot wrap
    localparam logic [DM_ADDR_LEN:0] LIMIT =
        {1'b0, BASE} + (DM_ADDR_LEN + 1)'(DEPTH * DM_BYTES);

    // Everything captured from the bus at the accept edge
    typedef struct packed {
        logic             oor;
        logic             wr;
        logic             ex;
        logic [IDX_W-1:0] idx;
        dm_be_t           be;
        dm_data_t         wdata;
    } req_t;

    dmem_resp_state_e state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic             busy_q, busy_d;
    req_t             req_q, req_d;
    req_t             req_live;
    req_t             txn;
    dm_data_t         rdata_q, rdata_d;
    logic [1:0]       bad_q, bad_d;
    logic             xstate_q, xstate_d;

    logic     accept;
    logic     commit;
    logic     mon_commit;
    logic     mon_xstate;
    logic     mem_we;
    dm_data_t rd_word;

    // Decode the live bus into a request record with range check and word index
    always_comb begin
        req_live.oor   = ({1'b0, dmem.dmem_addr} < {1'b0, BASE}) ||
                         ({1'b0, dmem.dmem_addr} >= LIMIT);
        req_live.wr    = dmem.dmem_wr;
        req_live.ex    = dmem.dmem_ex;
        req_live.idx   = IDX_W'((dmem.dmem_addr - BASE) >> DM_OFF_W);
        req_live.be    = dmem.dmem_byte;
        req_live.wdata = dmem.dmem_wdata;
    end

    assign accept = dmem.dmem_req && !busy_q;

    // Pick the transaction that commits this cycle: live bus with no wait
    // states, otherwise the record captured at accept
    always_comb begin
        if (WAIT == 0) begin
            commit = accept;
            txn    = req_live;
        end else begin
            commit = (state_q == DMEM_RESP_WAIT) && (cnt_q == 3'd1);
            txn    = req_q;
        end
    end

    // Sequencer: capture at accept, count down wait states, derive busy
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        case (state_q)
            DMEM_RESP_IDLE: begin
                if (accept) begin
                    req_d = req_live;
                    if (WAIT != 0) begin
                        state_d = DMEM_RESP_WAIT;
                        cnt_d   = 3'(WAIT);
                    end
                end
            end
            DMEM_RESP_WAIT: begin
                if (cnt_q == 3'd1) begin
                    state_d = DMEM_RESP_IDLE;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: begin
                state_d = DMEM_RESP_IDLE;
                cnt_d   = 3'd0;
            end
        endcase
        busy_d = (state_d == DMEM_RESP_WAIT);
    end

    // Out-of-range accesses never touch the array or the reservation
    assign mon_commit = commit && !txn.oor;
    // Stores write unless they are exclusive and lost the reservation
    assign mem_we     = mon_commit && txn.wr && (!txn.ex || mon_xstate);

    dmem_excl_mon #(
        .IDX_W (IDX_W)
    ) u_excl_mon (
        .clk    (clk),
        .rst    (rst),
        .commit (mon_commit),
        .ex     (txn.ex),
        .wr     (txn.wr),
        .idx    (txn.idx),
        .xstate (mon_xstate)
    );

    // Storage: one byte-wide array per lane, each with its own write enable
    for (genvar g = 0; g < DM_BYTES; g++) begin : g_lane
        logic [7:0] lane_mem [DEPTH];

        // Byte-lane write at commit
        always_ff @(posedge clk) begin
            // NOTE: the array has no reset on purpose; contents survive rst and this maps onto plain SRAM.
            if (mem_we && txn.be[g]) begin
                lane_mem[txn.idx] <= txn.wdata[8*g +: 8];
            end
        end

        assign rd_word[8*g +: 8] = lane_mem[txn.idx];
    end

    // Response values produced at commit, held until the next commit
    always_comb begin
        rdata_d  = rdata_q;
        bad_d    = bad_q;
        xstate_d = xstate_q;
        if (commit) begin
            if (txn.oor) begin
                rdata_d  = '0;
                bad_d    = DMEM_BAD_XES;
                xstate_d = 1'b0;
            end else begin
                bad_d    = DMEM_BAD_NONE;
                xstate_d = mon_xstate;
                if (!txn.wr) begin
                    rdata_d = rd_word;
                end
            end
        end
    end

    // Sequencer and response registers; reset drops any pending access
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= DMEM_RESP_IDLE;
            cnt_q    <= 3'd0;
            busy_q   <= 1'b0;
            req_q    <= '0;
            rdata_q  <= '0;
            bad_q    <= DMEM_BAD_NONE;
            xstate_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            req_q    <= req_d;
            rdata_q  <= rdata_d;
            bad_q    <= bad_d;
            xstate_q <= xstate_d;
        end
    end

    assign dmem.dmem_rdata  = rdata_q;
    assign dmem.dmem_bad    = bad_q;
    assign dmem.dmem_xstate = xstate_q;
    assign dmem.dmem_busy   = busy_q;

endmodule

// File: tb/tb_dmem_sram_resp.sv
// Directed bench for dmem_sram_resp: one instance with no wait states and
// one with three, driven through their own bus interfaces.
module tb_dmem_sram_resp;

    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          DEPTH = 64;
    localparam logic [31:0] LIMIT = BASE + DEPTH * 8;

    logic clk;
    logic rst;

    int n_total = 0;
    int n_bad   = 0;

    dmem_sram_resp_if if0 ();
    dmem_sram_resp_if if3 ();

    dmem_sram_resp #(.BASE(BASE), .DEPTH(DEPTH), .WAIT(0)) u_dut0 (
        .clk  (clk),
        .rst  (rst),
        .dmem (if0)
    );

    dmem_sram_resp #(.BASE(BASE), .DEPTH(DEPTH), .WAIT(3)) u_dut3 (
        .clk  (clk),
        .rst  (rst),
        .dmem (if3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input int sel, input logic req, input logic wr, input logic ex,
                         input logic [31:0] addr, input logic [7:0] be, input logic [63:0] wdata);
        if (sel == 0) begin
            if0.dmem_req = req; if0.dmem_wr = wr; if0.dmem_ex = ex;
            if0.dmem_addr = addr; if0.dmem_byte = be; if0.dmem_wdata = wdata;
        end else begin
            if3.dmem_req = req; if3.dmem_wr = wr; if3.dmem_ex = ex;
            if3.dmem_addr = addr; if3.dmem_byte = be; if3.dmem_wdata = wdata;
        end
    endtask

    function automatic logic get_busy(input int sel);
        return (sel == 0) ? if0.dmem_busy : if3.dmem_busy;
    endfunction

    // One complete transaction; returns the response-cycle outputs and the
    // number of busy cycles seen between accept and response
    task automatic access(input int sel, input logic wr, input logic ex,
                          input logic [31:0] addr, input logic [7:0] be, input logic [63:0] wdata,
                          output logic [63:0] rdata, output logic [1:0] bad,
                          output logic xs, output int busy_cycles);
        @(negedge clk);
        drive(sel, 1'b1, wr, ex, addr, be, wdata);
        @(posedge clk);
        #1;
        drive(sel, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        busy_cycles = 0;
        @(negedge clk);
        while (get_busy(sel) && busy_cycles < 16) begin
            busy_cycles++;
            @(negedge clk);
        end
        rdata = (sel == 0) ? if0.dmem_rdata  : if3.dmem_rdata;
        bad   = (sel == 0) ? if0.dmem_bad    : if3.dmem_bad;
        xs    = (sel == 0) ? if0.dmem_xstate : if3.dmem_xstate;
    endtask

    logic [63:0] r;
    logic [1:0]  b;
    logic        x;
    int          bc;

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        drive(3, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst0_busy",  if0.dmem_busy, 0);
        check("rst0_rdata", if0.dmem_rdata, 0);
        check("rst0_bad",   if0.dmem_bad, 0);
        check("rst0_xs",    if0.dmem_xstate, 0);
        check("rst3_busy",  if3.dmem_busy, 0);
        check("rst3_rdata", if3.dmem_rdata, 0);
        check("rst3_bad",   if3.dmem_bad, 0);
        check("rst3_xs",    if3.dmem_xstate, 0);

        // Full-word store then load, no wait states
        access(0, 1, 0, BASE, 8'hFF, 64'h1122334455667788, r, b, x, bc);
        check("t1_st_busy", bc, 0);
        check("t1_st_bad", b, 2'b00);
        access(0, 0, 0, BASE, 8'h00, 64'h0, r, b, x, bc);
        check("t1_ld_busy", bc, 0);
        check("t1_ld_data", r, 64'h1122334455667788);
        check("t1_ld_xs", x, 0);

        // Single-lane store: only lane 2 may change; store holds old rdata
        access(0, 1, 0, BASE + 32'h20, 8'hFF, 64'h0, r, b, x, bc);
        access(0, 1, 0, BASE + 32'h20, 8'h04, 64'hFFFF_FFFF_FFAB_FFFF, r, b, x, bc);
        check("t3_st_hold", r, 64'h1122334455667788);
        access(0, 0, 0, BASE + 32'h20, 8'h00, 64'h0, r, b, x, bc);
        check("t3_ld_data", r, 64'h0000_0000_00AB_0000);

        // Clear the words used by the reservation tests
        access(0, 1, 0, BASE + 32'h8,  8'hFF, 64'h0, r, b, x, bc);
        access(0, 1, 0, BASE + 32'h10, 8'hFF, 64'h0, r, b, x, bc);

        // LR then SC succeeds; a second SC fails and does not write
        access(0, 0, 1, BASE + 32'h8, 8'h00, 64'h0, r, b, x, bc);
        check("t4_lr_xs", x, 1);
        check("t4_lr_data", r, 64'h0);
        access(0, 1, 1, BASE + 32'h8, 8'h01, 64'h55, r, b, x, bc);
        check("t4_sc1_xs", x, 1);
        access(0, 0, 0, BASE + 32'h8, 8'h00, 64'h0, r, b, x, bc);
        check("t4_ld1_data", r, 64'h55);
        check("t4_ld1_xs", x, 0);
        access(0, 1, 1, BASE + 32'h8, 8'h01, 64'h66, r, b, x, bc);
        check("t4_sc2_xs", x, 0);
        access(0, 0, 0, BASE + 32'h8, 8'h00, 64'h0, r, b, x, bc);
        check("t4_ld2_data", r, 64'h55);

        // Plain store to the reserved word kills the reservation
        access(0, 0, 1, BASE + 32'h8, 8'h00, 64'h0, r, b, x, bc);
        access(0, 1, 0, BASE + 32'h8, 8'h01, 64'h77, r, b, x, bc);
        check("t5_st_xs", x, 0);
        access(0, 1, 1, BASE + 32'h8, 8'h01, 64'h88, r, b, x, bc);
        check("t5_sc_xs", x, 0);
        access(0, 0, 0, BASE + 32'h8, 8'h00, 64'h0, r, b, x, bc);
        check("t5_ld_data", r, 64'h77);

        // SC to a different word fails and does not write
        access(0, 0, 1, BASE + 32'h8, 8'h00, 64'h0, r, b, x, bc);
        access(0, 1, 1, BASE + 32'h10, 8'h01, 64'h99, r, b, x, bc);
        check("t5_scx_xs", x, 0);
        access(0, 0, 0, BASE + 32'h10, 8'h00, 64'h0, r, b, x, bc);
        check("t5_ldx_data", r, 64'h0);

        // A plain load between LR and SC leaves the reservation intact
        access(0, 0, 1, BASE + 32'h8, 8'h00, 64'h0, r, b, x, bc);
        access(0, 0, 0, BASE + 32'h8, 8'h00, 64'h0, r, b, x, bc);
        check("t5_pl_xs", x, 0);
        access(0, 1, 1, BASE + 32'h8, 8'h01, 64'hAA, r, b, x, bc);
        check("t5_pl_sc_xs", x, 1);
        access(0, 0, 0, BASE + 32'h8, 8'h00, 64'h0, r, b, x, bc);
        check("t5_pl_data", r, 64'hAA);

        // Range boundaries
        access(0, 0, 0, LIMIT, 8'h00, 64'h0, r, b, x, bc);
        check("t6_hi_bad", b, 2'b10);
        check("t6_hi_data", r, 64'h0);
        check("t6_hi_xs", x, 0);
        access(0, 0, 0, LIMIT - 32'h8, 8'h00, 64'h0, r, b, x, bc);
        check("t6_last_bad", b, 2'b00);
        access(0, 0, 0, BASE - 32'h8, 8'h00, 64'h0, r, b, x, bc);
        check("t6_lo_bad", b, 2'b10);
        // Out-of-range SC neither succeeds nor disturbs the reservation
        access(0, 0, 1, BASE + 32'h8, 8'h00, 64'h0, r, b, x, bc);
        access(0, 1, 1, LIMIT, 8'h01, 64'hCC, r, b, x, bc);
        check("t6_sc_oor_bad", b, 2'b10);
        check("t6_sc_oor_xs", x, 0);
        access(0, 1, 1, BASE + 32'h8, 8'h01, 64'hBB, r, b, x, bc);
        check("t6_sc_ok_xs", x, 1);
        check("t6_sc_ok_bad", b, 2'b00);
        access(0, 0, 0, BASE + 32'h8, 8'h00, 64'h0, r, b, x, bc);
        check("t6_sc_ok_data", r, 64'hBB);

        // Three wait states: busy for exactly three cycles per access
        access(3, 1, 0, BASE, 8'hFF, 64'hCAFE_0000_0000_0001, r, b, x, bc);
        check("w3_st_busy", bc, 3);
        access(3, 1, 0, BASE + 32'h8, 8'hFF, 64'hBEEF_0000_0000_0002, r, b, x, bc);
        check("w3_st2_busy", bc, 3);

        // Held request: the second load is taken only in the response cycle
        @(negedge clk);
        drive(3, 1'b1, 1'b0, 1'b0, BASE, 8'h00, 64'h0);
        @(posedge clk);
        #1;
        if3.dmem_addr = BASE + 32'h8;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            check($sformatf("w3_hold_busy_c%0d", c), if3.dmem_busy, 1);
        end
        @(negedge clk);
        check("w3_resp_busy", if3.dmem_busy, 0);
        check("w3_resp_data", if3.dmem_rdata, 64'hCAFE_0000_0000_0001);
        @(posedge clk);
        #1;
        drive(3, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        bc = 0;
        @(negedge clk);
        while (if3.dmem_busy && bc < 16) begin
            bc++;
            @(negedge clk);
        end
        check("w3_held_busy", bc, 3);
        check("w3_held_data", if3.dmem_rdata, 64'hBEEF_0000_0000_0002);

        // Reservation taken before the reset below
        access(3, 0, 1, BASE + 32'h8, 8'h00, 64'h0, r, b, x, bc);
        check("w3_lr_xs", x, 1);

        // Reset with a store pending: store lost, reservation cleared
        @(negedge clk);
        drive(3, 1'b1, 1'b1, 1'b0, BASE, 8'hFF, 64'hDEAD_DEAD_DEAD_DEAD);
        @(posedge clk);
        #1;
        drive(3, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);
        check("w3_pre_rst_busy", if3.dmem_busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check("w3_rst_busy", if3.dmem_busy, 0);
        check("w3_rst_rdata", if3.dmem_rdata, 64'h0);
        rst = 1'b0;
        access(3, 1, 1, BASE + 32'h8, 8'hFF, 64'h1234, r, b, x, bc);
        check("w3_post_sc_xs", x, 0);
        access(3, 0, 0, BASE, 8'h00, 64'h0, r, b, x, bc);
        check("w3_post_ld0", r, 64'hCAFE_0000_0000_0001);
        access(3, 0, 0, BASE + 32'h8, 8'h00, 64'h0, r, b, x, bc);
        check("w3_post_ld8", r, 64'hBEEF_0000_0000_0002);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
